dm_access_ctrl: RTL

- Memory-access controller between the processor's MA pipeline stage and the data memory (DM) block.
- Takes one load/store request per instruction and converts its byte address to a DM word address.
- Drives the DM ena/wea/addra/dina strobes, waits for the DM done handshake, returns read data and stalls the pipeline meanwhile.
- Flags illegal addresses and DM timeouts as a one-cycle error response, so a hung DM cannot freeze the core.

---
 rtl/dm_access_ctrl_pkg.sv | 15 +
 rtl/dm_timeout_ctr.sv | 23 ++
 rtl/dm_access_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared types and DM geometry for the MA-stage data-memory access path.
package dm_access_ctrl_pkg;

  localparam int unsigned DM_ADDR_W      = 7;
  localparam int unsigned DM_DATA_W      = 32;
  localparam int unsigned DM_TIMEOUT_DEF = 15;
  localparam int unsigned DM_CTR_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dm_timeout_ctr.sv
// Clear/enable up-counter with a terminal-count flag at TC-1.
module dm_timeout_ctr #(
  parameter int unsigned W  = 8,
  parameter int unsigned TC = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + W'(1);
  end

  assign o_tc_c = (r_cnt == W'(TC - 1));

endmodule

// File: rtl/dm_access_ctrl.sv
// MA-stage to data-memory controller: address check, DM strobes, done/timeout
// handling and a one-cycle response pulse that releases the pipeline stall.
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = DM_ADDR_W,
  parameter int unsigned DATA_W  = DM_DATA_W,
  parameter int unsigned TIMEOUT = DM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              DMclka,
  output logic              DMena,
  output logic              DMwea,
  output logic [ADDR_W-1:0] DMaddra,
  output logic [DATA_W-1:0] DMdina,
  input  logic [DATA_W-1:0] DMdouta,
  input  logic              DMdone
);

  dm_state_e         r_state, w_state_nxt;
  logic              r_dm_ena, w_dm_ena_nxt;
  logic              r_dm_wea, w_dm_wea_nxt;
  logic [ADDR_W-1:0] r_dm_addr, w_dm_addr_nxt;
  logic [DATA_W-1:0] r_dm_din, w_dm_din_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              w_ctr_clr, w_ctr_en, w_ctr_tc;
  logic              w_addr_ok;

  // Word aligned and inside the DM window.
  assign w_addr_ok = (req_addr[1:0] == 2'b00) &&
                     ((req_addr >> (ADDR_W + 2)) == 32'd0);

  dm_timeout_ctr #(
    .W  (DM_CTR_W),
    .TC (TIMEOUT)
  ) u_timeout_ctr (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_ctr_clr),
    .i_en    (w_ctr_en),
    .o_tc_c  (w_ctr_tc)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_dm_ena_nxt    = r_dm_ena;
    w_dm_wea_nxt    = r_dm_wea;
    w_dm_addr_nxt   = r_dm_addr;
    w_dm_din_nxt    = r_dm_din;
    w_rdata_nxt     = r_rdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_ctr_clr       = 1'b0;
    w_ctr_en        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_addr_ok) begin
            w_dm_ena_nxt  = 1'b1;
            w_dm_wea_nxt  = req_we;
            w_dm_addr_nxt = req_addr[ADDR_W+1:2];
            w_dm_din_nxt  = req_wdata;
            w_ctr_clr     = 1'b1;
            w_state_nxt   = ST_BUSY;
          end else begin
            w_rdata_nxt     = '0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_state_nxt     = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        // Done takes priority over a coincident timeout.
        if (DMdone) begin
          w_rdata_nxt     = r_dm_wea ? '0 : DMdouta;
          w_dm_ena_nxt    = 1'b0;
          w_dm_wea_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RESP;
        end else if (w_ctr_tc) begin
          w_rdata_nxt     = '0;
          w_dm_ena_nxt    = 1'b0;
          w_dm_wea_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_state_nxt     = ST_RESP;
        end else begin
          w_ctr_en = 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_dm_ena    <= 1'b0;
      r_dm_wea    <= 1'b0;
      r_dm_addr   <= '0;
      r_dm_din    <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dm_ena    <= w_dm_ena_nxt;
      r_dm_wea    <= w_dm_wea_nxt;
      r_dm_addr   <= w_dm_addr_nxt;
      r_dm_din    <= w_dm_din_nxt;
      r_rdata     <= w_rdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign stall     = req_valid & ~r_rsp_valid;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_rsp_err;
  assign DMclka    = clk;
  assign DMena     = r_dm_ena;
  assign DMwea     = r_dm_wea;
  assign DMaddra   = r_dm_addr;
  assign DMdina    = r_dm_din;

endmodule
